riscv_decode_stage: RTL and testbench
=====================================

RISCV_DECODE_STAGE -- requirements
Module: riscv_decode_stage

Interface
REQ-001 Parameter SKID_EN, default 1; 1 = two-entry skid buffer (full throughput under backpressure), 0 = single output register.
REQ-002 Parameter ILL_CNT_W, default 16; width of the saturating illegal-instruction counter.
REQ-003 Parameter FENCE_LEGAL, default 1; 1 = MISC-MEM decodes as legal NOP, 0 = illegal.
REQ-004 clk_i  in  1  sole clock; all state is updated on its rising edge.
REQ-005 rst_n_i  in  1  reset, asynchronous and active-low.
REQ-006 in_valid_i / in_ready_o  in/out  1/1  fetch-side handshake.
REQ-007 fetched_instr_i, pc_i  in  32/32  instruction word and its PC.
REQ-008 flush_i  in  1  discard all held entries.
REQ-009 out_valid_o / out_ready_i  out/in  1/1  execute-side handshake.
REQ-010 pc_o, instr_o  out  32/32  PC and instruction word of the presented entry.
REQ-011 ex_op_a_sel_o 2, ex_op_b_sel_o 3, alu_op_o ALU_OP_WIDTH, mem_req_o 1, mem_we_o 1, mem_size_o 3, gpr_we_a_o 1, wb_src_sel_o 1, illegal_instr_o 1, branch_o 1, jal_o 1, jalr_o 1  out  decoded fields of the presented entry.
REQ-012 ill_cnt_o  out  ILL_CNT_W  count of illegal instructions accepted at the output.

Function
REQ-013 Decode covers full RV32I: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM (incl. SLLI/SRLI/SRAI), OP, MISC-MEM, SYSTEM (ECALL/EBREAK).
REQ-014 Illegal: bits[1:0] != 2'b11, unknown opcode, unsupported funct3/funct7, SYSTEM, or MISC-MEM with FENCE_LEGAL=0.
REQ-015 When illegal_instr_o=1, mem_req_o, mem_we_o, gpr_we_a_o, branch_o, jal_o, jalr_o are 0.
REQ-016 LOAD: mem_req=1, mem_we=0, wb_src_sel=1, gpr_we=1, ALU ADD, op_a RS1, op_b IMM_I; mem_size B/H/W/BU/HU = 0/1/2/4/5.
REQ-017 STORE: mem_req=1, mem_we=1, gpr_we=0, op_b IMM_S; funct3 > 2 illegal.
REQ-018 JAL/JALR: op_a CURR_PC, op_b INCR (4), ALU ADD, gpr_we=1; JALR with funct3 != 0 illegal.
REQ-019 LUI: op_a ZERO, op_b IMM_U; AUIPC: op_a CURR_PC, op_b IMM_U; both gpr_we=1.
REQ-020 BRANCH: branch_o=1, op_a RS1, op_b RS2, compare ALU op per funct3; funct3 2/3 illegal.
REQ-021 Latency: accepted instruction appears at the output the cycle after the in_valid_i & in_ready_o edge.
REQ-022 Transfer occurs only when valid & ready both 1 on a rising edge; out_valid_o and output data stay stable until accepted.
REQ-023 SKID_EN=1: in_ready_o = skid slot empty (registered); one instruction per cycle sustained; order preserved.
REQ-024 SKID_EN=0: in_ready_o = !out_valid_o | out_ready_i.
REQ-025 flush_i: next cycle out_valid_o=0 and skid empty; an input handshake in the same cycle is discarded; flush has priority over all handshakes.
REQ-026 ill_cnt_o increments by 1 when an entry with illegal_instr_o=1 is accepted at the output; saturates at all-ones; flushed entries are not counted.
REQ-027 Decoded fields when out_valid_o=0 are don't-care; only out_valid_o is relied on.

Reset
REQ-028 While rst_n_i=0: out_valid_o=0, skid empty, in_ready_o=0, ill_cnt_o=0, all output registers 0.
REQ-029 in_ready_o rises the first cycle after rst_n_i deasserts; reset mid-transfer drops all held entries.

Structure
REQ-030 riscv_pkg holds opcodes, ALU_OP_WIDTH and ALU op codes, OP_A (RS1=0, CURR_PC=1, ZERO=2), OP_B (RS2=0, IMM_I=1, IMM_U=2, IMM_S=3, INCR=4), LDST codes.
REQ-031 Combinational decode is sub-module riscv_decode_comb; stage holds handshake, skid and counter only.

Verification
REQ-032 0x002081B3 (ADD), ready=1 -> next cycle out_valid=1, alu ADD, gpr_we=1, illegal=0; 0x402081B3 -> ALU SUB.
REQ-033 0x0040A283 (LW) -> mem_req=1, mem_we=0, mem_size=2, wb_src_sel=1; 0x0020A023 (SW) -> mem_we=1, gpr_we=0.
REQ-034 0x00000000 then 0x00000073 -> illegal=1 both, side-effect outputs 0, ill_cnt_o=2 after acceptance.
REQ-035 Stream of 4 instructions, out_ready_i=0 for 3 cycles -> no loss, order preserved, in_ready_o=0 while skid full, full rate resumes.
REQ-036 flush_i with 2 held entries -> out_valid_o=0 next cycle, ill_cnt_o unchanged; rst_n_i low mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I opcodes, operand selects, ALU codes and decode entry types
package riscv_pkg;
  localparam int ALU_OP_WIDTH = 4;
  typedef enum logic [6:0] {
    OPC_LOAD = 7'h03, OPC_MISC_MEM = 7'h0f, OPC_OP_IMM = 7'h13, OPC_AUIPC = 7'h17,
    OPC_STORE = 7'h23, OPC_OP = 7'h33, OPC_LUI = 7'h37, OPC_BRANCH = 7'h63,
    OPC_JALR = 7'h67, OPC_JAL = 7'h6f, OPC_SYSTEM = 7'h73
  } opcode_e;
  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_EQ, ALU_NE, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU
  } alu_op_e;
  typedef enum logic [1:0] {OP_A_RS1, OP_A_CURR_PC, OP_A_ZERO} op_a_e;
  typedef enum logic [2:0] {OP_B_RS2, OP_B_IMM_I, OP_B_IMM_U, OP_B_IMM_S, OP_B_INCR} op_b_e;
  localparam logic [2:0] LDST_B = 3'd0, LDST_H = 3'd1, LDST_W = 3'd2, LDST_BU = 3'd4, LDST_HU = 3'd5;
  typedef struct packed {
    op_a_e       op_a;
    op_b_e       op_b;
    alu_op_e     alu_op;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  mem_size;
    logic        gpr_we;
    logic        wb_src;
    logic        illegal;
    logic        branch;
    logic        jal;
    logic        jalr;
  } dec_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    dec_t        dec;
  } entry_t;
  function automatic alu_op_e alu_f3(input logic [2:0] f3, input logic alt);
    alu_op_e r;
    case (f3)
      3'd0: r = alt ? ALU_SUB : ALU_ADD;
      3'd1: r = ALU_SLL;
      3'd2: r = ALU_SLT;
      3'd3: r = ALU_SLTU;
      3'd4: r = ALU_XOR;
      3'd5: r = alt ? ALU_SRA : ALU_SRL;
      3'd6: r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/riscv_decode_comb.sv
// riscv_decode_comb: purely combinational RV32I field decode
module riscv_decode_comb
  import riscv_pkg::*;
#(
  parameter int unsigned FENCE_LEGAL = 1
) (
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output dec_t       dec_o
);
  logic ill;
  always_comb begin
    dec_o = '0;
    ill = 1'b0;
    case (opcode_i)
      OPC_LUI: begin
        dec_o.op_a = OP_A_ZERO;
        dec_o.op_b = OP_B_IMM_U;
        dec_o.gpr_we = 1'b1;
      end
      OPC_AUIPC: begin
        dec_o.op_a = OP_A_CURR_PC;
        dec_o.op_b = OP_B_IMM_U;
        dec_o.gpr_we = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        dec_o.op_a = OP_A_CURR_PC;
        dec_o.op_b = OP_B_INCR;
        dec_o.gpr_we = 1'b1;
        dec_o.jal = opcode_i == OPC_JAL;
        dec_o.jalr = opcode_i == OPC_JALR;
        ill = opcode_i == OPC_JALR && funct3_i != 3'd0;
      end
      OPC_BRANCH: begin
        dec_o.branch = 1'b1;
        // EQ/NE sit at 10/11 and LT..GEU at 12..15, so funct3 maps by concatenation
        dec_o.alu_op = alu_op_e'(funct3_i[2] ? {2'b11, funct3_i[1:0]} : {3'b101, funct3_i[0]});
        ill = funct3_i[2:1] == 2'b01;
      end
      OPC_LOAD: begin
        dec_o.op_b = OP_B_IMM_I;
        dec_o.mem_req = 1'b1;
        dec_o.mem_size = funct3_i;
        dec_o.wb_src = 1'b1;
        dec_o.gpr_we = 1'b1;
        ill = funct3_i == 3'd3 || funct3_i[2:1] == 2'b11;
      end
      OPC_STORE: begin
        dec_o.op_b = OP_B_IMM_S;
        dec_o.mem_req = 1'b1;
        dec_o.mem_we = 1'b1;
        dec_o.mem_size = funct3_i;
        ill = funct3_i > 3'd2;
      end
      OPC_OP_IMM: begin
        dec_o.op_b = OP_B_IMM_I;
        dec_o.gpr_we = 1'b1;
        dec_o.alu_op = alu_f3(funct3_i, funct3_i == 3'd5 && funct7_i[5]);
        ill = (funct3_i == 3'd1 && funct7_i != 7'd0) ||
              (funct3_i == 3'd5 && (funct7_i & 7'b1011111) != 7'd0);
      end
      OPC_OP: begin
        dec_o.gpr_we = 1'b1;
        dec_o.alu_op = alu_f3(funct3_i, funct7_i[5]);
        ill = (funct7_i & 7'b1011111) != 7'd0 ||
              (funct7_i[5] && funct3_i != 3'd0 && funct3_i != 3'd5);
      end
      OPC_MISC_MEM: ill = FENCE_LEGAL == 0;
      default: ill = 1'b1;
    endcase
    ill = ill | (opcode_i[1:0] != 2'b11);
    dec_o.illegal = ill;
    if (ill) begin
      dec_o.mem_req = 1'b0;
      dec_o.mem_we = 1'b0;
      dec_o.gpr_we = 1'b0;
      dec_o.branch = 1'b0;
      dec_o.jal = 1'b0;
      dec_o.jalr = 1'b0;
    end
  end
endmodule

// File: rtl/riscv_decode_stage.sv
// riscv_decode_stage: registered decode stage with optional skid slot and illegal counter
module riscv_decode_stage
  import riscv_pkg::*;
#(
  parameter int unsigned SKID_EN     = 1,
  parameter int unsigned ILL_CNT_W   = 16,
  parameter int unsigned FENCE_LEGAL = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [31:0]             fetched_instr_i,
  input  logic [31:0]             pc_i,
  input  logic                    flush_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [31:0]             pc_o,
  output logic [31:0]             instr_o,
  output logic [1:0]              ex_op_a_sel_o,
  output logic [2:0]              ex_op_b_sel_o,
  output logic [ALU_OP_WIDTH-1:0] alu_op_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [2:0]              mem_size_o,
  output logic                    gpr_we_a_o,
  output logic                    wb_src_sel_o,
  output logic                    illegal_instr_o,
  output logic                    branch_o,
  output logic                    jal_o,
  output logic                    jalr_o,
  output logic [ILL_CNT_W-1:0]    ill_cnt_o
);
  dec_t in_dec;
  entry_t in_e, out_q, out_d, skid_q, skid_d;
  logic out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, active_q, active_d;
  logic in_fire, out_fire;
  logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;
  riscv_decode_comb #(.FENCE_LEGAL(FENCE_LEGAL)) u_dec (
    .opcode_i(fetched_instr_i[6:0]),
    .funct3_i(fetched_instr_i[14:12]),
    .funct7_i(fetched_instr_i[31:25]),
    .dec_o   (in_dec)
  );
  assign in_e = {pc_i, fetched_instr_i, in_dec};
  // active_q holds ready low through reset and for the first edge after it
  assign active_d = 1'b1;
  assign in_ready_o = active_q & ((SKID_EN != 0) ? !skid_valid_q : (!out_valid_q | out_ready_i));
  assign in_fire = in_valid_i & in_ready_o;
  assign out_fire = out_valid_q & out_ready_i;
  always_comb begin
    out_d = out_q;
    skid_d = skid_q;
    out_valid_d = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_fire) begin
      out_valid_d = skid_valid_q | in_fire;
      out_d = skid_valid_q ? skid_q : in_e;
      skid_valid_d = 1'b0;
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_d = in_e;
    end
    ill_cnt_d = (!flush_i && out_fire && out_q.dec.illegal && !(&ill_cnt_q)) ?
                ill_cnt_q + ILL_CNT_W'(1) : ill_cnt_q;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_q <= '0;
      skid_q <= '0;
      out_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      active_q <= 1'b0;
      ill_cnt_q <= '0;
    end else begin
      out_q <= out_d;
      skid_q <= skid_d;
      out_valid_q <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      active_q <= active_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end
  assign out_valid_o = out_valid_q;
  assign pc_o = out_q.pc;
  assign instr_o = out_q.instr;
  assign ex_op_a_sel_o = out_q.dec.op_a;
  assign ex_op_b_sel_o = out_q.dec.op_b;
  assign alu_op_o = out_q.dec.alu_op;
  assign mem_req_o = out_q.dec.mem_req;
  assign mem_we_o = out_q.dec.mem_we;
  assign mem_size_o = out_q.dec.mem_size;
  assign gpr_we_a_o = out_q.dec.gpr_we;
  assign wb_src_sel_o = out_q.dec.wb_src;
  assign illegal_instr_o = out_q.dec.illegal;
  assign branch_o = out_q.dec.branch;
  assign jal_o = out_q.dec.jal;
  assign jalr_o = out_q.dec.jalr;
  assign ill_cnt_o = ill_cnt_q;
endmodule

// File: tb/tb_riscv_decode_stage.sv
// tb_riscv_decode_stage: directed self-checking bench for the decode stage
module tb_riscv_decode_stage;
  logic clk_i = 1'b0, rst_n_i = 1'b0, in_valid_i = 1'b0, flush_i = 1'b0, out_ready_i = 1'b0;
  logic [31:0] fetched_instr_i = '0, pc_i = '0;
  logic in_ready_o, out_valid_o, mem_req_o, mem_we_o, gpr_we_a_o, wb_src_sel_o;
  logic illegal_instr_o, branch_o, jal_o, jalr_o;
  logic [31:0] pc_o, instr_o;
  logic [1:0] ex_op_a_sel_o;
  logic [2:0] ex_op_b_sel_o, mem_size_o;
  logic [3:0] alu_op_o;
  logic [15:0] ill_cnt_o;
  int n_chk = 0, n_fail = 0;
  logic [31:0] pc = 32'h100;
  riscv_decode_stage dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .fetched_instr_i(fetched_instr_i), .pc_i(pc_i), .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .pc_o(pc_o), .instr_o(instr_o),
    .ex_op_a_sel_o(ex_op_a_sel_o), .ex_op_b_sel_o(ex_op_b_sel_o), .alu_op_o(alu_op_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_size_o(mem_size_o),
    .gpr_we_a_o(gpr_we_a_o), .wb_src_sel_o(wb_src_sel_o), .illegal_instr_o(illegal_instr_o),
    .branch_o(branch_o), .jal_o(jal_o), .jalr_o(jalr_o), .ill_cnt_o(ill_cnt_o)
  );
  always #5 clk_i = ~clk_i;
  wire logic [16:0] act_f = {ex_op_a_sel_o, ex_op_b_sel_o, alu_op_o, gpr_we_a_o, wb_src_sel_o,
                             mem_req_o, mem_we_o, branch_o, jal_o, jalr_o, illegal_instr_o};
  wire logic [6:0] act_s = {illegal_instr_o, mem_req_o, mem_we_o, gpr_we_a_o, branch_o, jal_o, jalr_o};
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic logic [16:0] fv(input logic [1:0] a, input logic [2:0] b, input logic [3:0] alu,
                                     input logic [7:0] flags);
    return {a, b, alu, flags};
  endfunction
  task automatic push(input logic [31:0] ins, input logic [31:0] p);
    in_valid_i = 1'b1;
    fetched_instr_i = ins;
    pc_i = p;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
  endtask
  // flags: gpr wb mreq mwe br jal jalr ill
  task automatic vec(input logic [31:0] ins, input logic [16:0] e, input logic [2:0] sz);
    push(ins, pc);
    check($sformatf("valid %h", ins), out_valid_o, 1);
    check($sformatf("pc %h", ins), pc_o, pc);
    check($sformatf("fields %h", ins), act_f, e);
    if (e[5]) check($sformatf("size %h", ins), mem_size_o, sz);
    pc = pc + 4;
  endtask
  task automatic ill(input logic [31:0] ins);
    push(ins, pc);
    check($sformatf("illegal %h", ins), act_s, 7'b1000000);
    pc = pc + 4;
  endtask
  initial begin
    int rd = 0, wr = 0, last = -1;
    #12;
    check("rst valid", out_valid_o, 0);
    check("rst ready", in_ready_o, 0);
    check("rst cnt", ill_cnt_o, 0);
    check("rst pc", pc_o, 0);
    check("rst fields", act_f, 0);
    rst_n_i = 1'b1;
    #1;
    check("ready before edge", in_ready_o, 0);
    @(posedge clk_i);
    #1;
    check("ready after rst", in_ready_o, 1);
    out_ready_i = 1'b1;
    vec(32'h002081B3, fv(0, 0, 0,  8'b1000_0000), 0);
    vec(32'h402081B3, fv(0, 0, 1,  8'b1000_0000), 0);
    vec(32'h4020D1B3, fv(0, 0, 7,  8'b1000_0000), 0);
    vec(32'h0040A283, fv(0, 1, 0,  8'b1110_0000), 2);
    vec(32'h00005083, fv(0, 1, 0,  8'b1110_0000), 5);
    vec(32'h0020A023, fv(0, 3, 0,  8'b0011_0000), 2);
    vec(32'h123450B7, fv(2, 2, 0,  8'b1000_0000), 0);
    vec(32'h00000097, fv(1, 2, 0,  8'b1000_0000), 0);
    vec(32'h0000006F, fv(1, 4, 0,  8'b1000_0100), 0);
    vec(32'h000080E7, fv(1, 4, 0,  8'b1000_0010), 0);
    vec(32'h00208063, fv(0, 0, 10, 8'b0000_1000), 0);
    vec(32'h0020C063, fv(0, 0, 12, 8'b0000_1000), 0);
    vec(32'h4010D093, fv(0, 1, 7,  8'b1000_0000), 0);
    vec(32'h0FF0F093, fv(0, 1, 4,  8'b1000_0000), 0);
    push(32'h0000000F, pc);
    check("fence", act_s, 7'b0000000);
    ill(32'h00000000);
    ill(32'h00000073);
    @(posedge clk_i);
    #1;
    check("cnt two", ill_cnt_o, 2);
    ill(32'h000090E7);
    ill(32'h0020B063);
    ill(32'h0020B023);
    ill(32'h020081B3);
    ill(32'h0000007F);
    @(posedge clk_i);
    #1;
    check("cnt seven", ill_cnt_o, 7);
    check("drained", out_valid_o, 0);
    out_ready_i = 1'b0;
    for (int c = 0; c < 12; c++) begin
      out_ready_i = c >= 3;
      in_valid_i = wr < 4;
      fetched_instr_i = 32'h00000013 | (32'(wr + 1) << 7);
      pc_i = 32'h200 + 32'(wr) * 4;
      #1;
      if (c == 2) check("bp ready full", in_ready_o, 0);
      if (out_valid_o && out_ready_i) begin
        check($sformatf("bp pc %0d", rd), pc_o, 32'h200 + 32'(rd) * 4);
        check($sformatf("bp instr %0d", rd), instr_o, 32'h00000013 | (32'(rd + 1) << 7));
        rd++;
        last = c;
      end
      if (in_valid_i && in_ready_o) wr++;
      @(posedge clk_i);
      #1;
    end
    in_valid_i = 1'b0;
    check("bp count", rd, 4);
    check("bp last cycle", last, 6);
    out_ready_i = 1'b0;
    push(32'h00000000, 32'h300);
    push(32'h002081B3, 32'h304);
    check("two held valid", out_valid_o, 1);
    check("two held ready", in_ready_o, 0);
    flush_i = 1'b1;
    out_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    check("flush valid", out_valid_o, 0);
    check("flush cnt", ill_cnt_o, 7);
    check("flush ready", in_ready_o, 1);
    flush_i = 1'b1;
    push(32'h002081B3, 32'h308);
    flush_i = 1'b0;
    check("flush drop in", out_valid_o, 0);
    @(posedge clk_i);
    #1;
    check("flush drop stays", out_valid_o, 0);
    out_ready_i = 1'b0;
    push(32'h00000000, 32'h400);
    push(32'h402081B3, 32'h404);
    #2;
    rst_n_i = 1'b0;
    #1;
    check("arst valid", out_valid_o, 0);
    check("arst ready", in_ready_o, 0);
    check("arst cnt", ill_cnt_o, 0);
    check("arst pc", pc_o, 0);
    check("arst instr", instr_o, 0);
    check("arst fields", act_f, 0);
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("post rst ready", in_ready_o, 1);
    check("post rst valid", out_valid_o, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
